// File: rtl/mem_bus_stage_pkg.sv
// Shared pipeline defines plus MEM-stage types: op decode result and the
// registered bus command payload.
`ifndef MEM_BUS_STAGE_DEFINES
`define MEM_BUS_STAGE_DEFINES
`define ZeroWord    32'h00000000
`define RegBus      31:0
`define RegAddrBus  4:0
`define AluOpBus    7:0
`define EXE_NOP_OP  8'b00000000
`define EXE_ADDU_OP 8'b00100001
`define EXE_OR_OP   8'b00100101
`define EXE_LB_OP   8'b11100000
`define EXE_LBU_OP  8'b11100100
`define EXE_LH_OP   8'b11100001
`define EXE_LHU_OP  8'b11100101
`define EXE_LW_OP   8'b11100011
`define EXE_SB_OP   8'b11101000
`define EXE_SH_OP   8'b11101001
`define EXE_SW_OP   8'b11101011
`endif

package mem_bus_stage_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned SEL_W      = 4;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned ALUOP_W    = 8;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_e;

    typedef struct packed {
        logic      is_mem;
        logic      is_store;
        mem_size_e size;
        logic      sign_ext;
    } mem_op_t;

    typedef struct packed {
        logic              req;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] wdata;
    } bus_cmd_t;

    // Classify an aluop; anything outside the eight load/store codes is non-memory.
    function automatic mem_op_t decode_mem_op(input logic [ALUOP_W-1:0] aluop);
        mem_op_t op;
        op        = '0;
        op.is_mem = 1'b1;
        op.size   = SZ_WORD;
        case (aluop)
            `EXE_LB_OP:  begin op.size = SZ_BYTE; op.sign_ext = 1'b1; end
            `EXE_LBU_OP: op.size = SZ_BYTE;
            `EXE_LH_OP:  begin op.size = SZ_HALF; op.sign_ext = 1'b1; end
            `EXE_LHU_OP: op.size = SZ_HALF;
            `EXE_LW_OP:  op.size = SZ_WORD;
            `EXE_SB_OP:  begin op.size = SZ_BYTE; op.is_store = 1'b1; end
            `EXE_SH_OP:  begin op.size = SZ_HALF; op.is_store = 1'b1; end
            `EXE_SW_OP:  begin op.size = SZ_WORD; op.is_store = 1'b1; end
            default:     op.is_mem = 1'b0;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mem_bus_stage_if.sv
// Request/acknowledge data bus between the MEM stage (master) and memory (slave).
interface mem_bus_stage_if;
    import mem_bus_stage_pkg::*;

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, sel, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, sel, wdata,
        output ack, rdata
    );

endinterface

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane steering: lane selects, store replication, load
// extract with sign/zero extension, and alignment check.
module mem_lane_align
    import mem_bus_stage_pkg::*;
(
    input  mem_op_t           op,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] store_src,
    input  logic [DATA_W-1:0] load_src,
    output logic [SEL_W-1:0]  sel_c,
    output logic [DATA_W-1:0] store_data_c,
    output logic [DATA_W-1:0] load_data_c,
    output logic              misalign_c
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        sel_c        = '0;
        store_data_c = '0;
        load_data_c  = '0;
        misalign_c   = 1'b0;
        lane_byte    = '0;
        lane_half    = '0;

        case (op.size)
            SZ_BYTE: begin
                sel_c        = 4'b1000 >> addr_lo;
                store_data_c = {4{store_src[7:0]}};
                case (addr_lo)
                    2'd0:    lane_byte = load_src[31:24];
                    2'd1:    lane_byte = load_src[23:16];
                    2'd2:    lane_byte = load_src[15:8];
                    default: lane_byte = load_src[7:0];
                endcase
                load_data_c = op.sign_ext ? {{24{lane_byte[7]}}, lane_byte}
                                          : {24'h000000, lane_byte};
            end
            SZ_HALF: begin
                misalign_c   = addr_lo[0];
                sel_c        = addr_lo[1] ? 4'b0011 : 4'b1100;
                store_data_c = {2{store_src[15:0]}};
                lane_half    = addr_lo[1] ? load_src[15:0] : load_src[31:16];
                load_data_c  = op.sign_ext ? {{16{lane_half[15]}}, lane_half}
                                           : {16'h0000, lane_half};
            end
            default: begin
                misalign_c   = |addr_lo;
                sel_c        = 4'b1111;
                store_data_c = store_src;
                load_data_c  = load_src;
            end
        endcase

        // Stores have no load result; non-memory ops drive nothing.
        if (op.is_store) begin
            load_data_c = '0;
        end
        if (!op.is_mem) begin
            sel_c        = '0;
            store_data_c = '0;
            load_data_c  = '0;
            misalign_c   = 1'b0;
        end
    end

endmodule

// File: rtl/mem_bus_stage.sv
// Pipeline MEM stage: runs loads/stores over the req/ack bus, stalls the
// pipeline while pending, and forwards the write-back triple to MEM/WB.
module mem_bus_stage
    import mem_bus_stage_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = 255
)
(
    input  logic                  clk,
    input  logic                  rst,

    input  logic [`RegAddrBus]    mem_wd,
    input  logic                  mem_wreg,
    input  logic [`RegBus]        mem_wdata,
    input  logic [`AluOpBus]      mem_aluop,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [`RegBus]        mem_reg2,
    input  logic                  flush,

    output logic [`RegAddrBus]    wd,
    output logic                  wreg,
    output logic [`RegBus]        wdata,
    output logic                  stallreq,
    output logic                  exc_misalign,
    output logic                  bus_err,

    mem_bus_stage_if.master       bus
);

    localparam int unsigned CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    bus_cmd_t          cmd;
    logic              bus_err_q;
    logic [DATA_W-1:0] load_buf;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              abort_q;
    logic              timed_out_q;

    mem_op_t           op;
    logic [SEL_W-1:0]  lane_sel;
    logic [DATA_W-1:0] lane_store;
    logic [DATA_W-1:0] lane_load;
    logic              lane_misalign;
    logic              start_access;
    logic              timeout_hit;

    assign op = decode_mem_op(mem_aluop);

    mem_lane_align u_lane_align (
        .op           (op),
        .addr_lo      (mem_addr[1:0]),
        .store_src    (mem_reg2),
        .load_src     (bus.rdata),
        .sel_c        (lane_sel),
        .store_data_c (lane_store),
        .load_data_c  (lane_load),
        .misalign_c   (lane_misalign)
    );

    assign start_access = op.is_mem && !lane_misalign && !flush;
    assign cnt_nxt      = cnt + CNT_W'(1);
    assign timeout_hit  = (BUS_TIMEOUT != 0) && (cnt_nxt == CNT_W'(BUS_TIMEOUT));

    // State, bus command, load buffer and timeout bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cmd         <= '{req: 1'b0, we: 1'b0, addr: `ZeroWord, sel: '0, wdata: `ZeroWord};
            bus_err_q   <= 1'b0;
            load_buf    <= `ZeroWord;
            cnt         <= '0;
            abort_q     <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_access) begin
                        cmd.req     <= 1'b1;
                        cmd.we      <= op.is_store;
                        cmd.addr    <= {mem_addr[ADDR_W-1:2], 2'b00};
                        cmd.sel     <= lane_sel;
                        cmd.wdata   <= lane_store;
                        cnt         <= '0;
                        abort_q     <= 1'b0;
                        timed_out_q <= 1'b0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt_nxt;
                    if (flush) begin
                        abort_q <= 1'b1;
                    end
                    // A flushed access still runs to ack or timeout; only its result is dropped.
                    if (bus.ack) begin
                        load_buf <= lane_load;
                        cmd.req  <= 1'b0;
                        state    <= DONE;
                    end else if (timeout_hit) begin
                        cmd.req     <= 1'b0;
                        bus_err_q   <= 1'b1;
                        timed_out_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req   = cmd.req;
    assign bus.we    = cmd.we;
    assign bus.addr  = cmd.addr;
    assign bus.sel   = cmd.sel;
    assign bus.wdata = cmd.wdata;
    assign bus_err   = bus_err_q;

    // Write-back and stall outputs; non-memory ops pass straight through in IDLE.
    always_comb begin
        wd           = mem_wd;
        wreg         = 1'b0;
        wdata        = mem_wdata;
        stallreq     = 1'b0;
        exc_misalign = 1'b0;
        case (state)
            IDLE: begin
                if (!op.is_mem) begin
                    wreg = mem_wreg & ~flush;
                end else if (!flush) begin
                    if (lane_misalign) begin
                        exc_misalign = 1'b1;
                    end else begin
                        stallreq = 1'b1;
                    end
                end
            end
            WAIT: begin
                stallreq = 1'b1;
            end
            DONE: begin
                wdata = load_buf;
                if (!op.is_store && !abort_q && !timed_out_q && !flush) begin
                    wreg = mem_wreg;
                end
            end
            default: ;
        endcase
    end

endmodule
